ysyx_23060236_scoreboard_regfile: RTL



---
 rtl/ysyx_23060236_scoreboard_regfile.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060236_scoreboard_regfile.sv
// ysyx_23060236_scoreboard_regfile
//
// Integer register file with a per-register pending-write scoreboard.
// Decode reads operands and busy status through NR_READ combinational read
// ports and reserves its destination through the issue port; writeback
// writes the data and retires one reservation. Entry 0 reads as zero and is
// never busy.
//
// Optional feature: define YSYX_23060236_RF_BYPASS_EN to forward a
// same-cycle writeback onto the read ports and into the issue-ready check.
// Without the macro, reads and issue_ready see only registered state.

module ysyx_23060236_scoreboard_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic                          wb_valid,
  input  logic [ADDR_WIDTH-1:0]         wb_rd,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic                          flush
);

  localparam int                   NR_REGS = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Entry 0 of both arrays is cleared by reset and never written, so it
  // stays zero and folds away in synthesis.
  logic [DATA_WIDTH-1:0] r_data [NR_REGS];
  logic [CNT_WIDTH-1:0]  r_cnt  [NR_REGS];

  logic                  w_wb_en;
  logic                  w_issue_fire;
  logic [NR_REGS-1:1]    w_inc;
  logic [NR_REGS-1:1]    w_dec;
  logic                  w_issue_hit;
  logic [CNT_WIDTH-1:0]  w_issue_cnt;

  assign w_wb_en      = wb_valid & (wb_rd != '0);
  assign w_issue_fire = issue_valid & issue_ready & ~flush;

  // Per-entry reservation (inc) and retirement (dec) strobes for this edge.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; no latch is inferred.
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NR_REGS; i++) begin
      w_inc[i] = w_issue_fire & (issue_rd == ADDR_WIDTH'(i));
      w_dec[i] = wb_valid & (wb_rd == ADDR_WIDTH'(i)) & (r_cnt[i] != '0);
    end
  end

  // Data array: writeback is never gated by the scoreboard or by flush.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the array has a reset because post-reset zero contents are
    // architecturally visible; a plain RAM without reset would not satisfy that.
    if (!resetn) begin
      for (int i = 0; i < NR_REGS; i++) r_data[i] <= '0;
    end else if (w_wb_en) begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      r_data[wb_rd] <= wb_data;
    end
  end

  // Pending-write counters: flush clears all, otherwise +inc -dec per entry.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NR_REGS; i++) r_cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 1; i < NR_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NR_REGS; i++) begin
        if (w_inc[i] & ~w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] & ~w_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // Issue-ready: a destination can take another reservation unless its
  // counter is saturated. With forwarding, a writeback retiring a reservation
  // in this same cycle frees a slot immediately.
`ifdef YSYX_23060236_RF_BYPASS_EN
  assign w_issue_hit = wb_valid & (wb_rd == issue_rd) & (r_cnt[issue_rd] != '0);
`else
  assign w_issue_hit = 1'b0;
`endif
  assign w_issue_cnt = w_issue_hit ? (r_cnt[issue_rd] - 1'b1) : r_cnt[issue_rd];
  assign issue_ready = (issue_rd == '0) | (w_issue_cnt != CNT_MAX);

  // Read ports: combinational; index 0 always yields zero and not busy.
  for (genvar p = 0; p < NR_READ; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_hit;

    assign w_addr = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef YSYX_23060236_RF_BYPASS_EN
    // Forwarding is suppressed during reset so the ports read zero there.
    assign w_hit = resetn & wb_valid & (wb_rd == w_addr) & (w_addr != '0);
`else
    assign w_hit = 1'b0;
`endif

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] =
        (w_addr == '0) ? '0 :
        w_hit          ? wb_data :
                         r_data[w_addr];

    // A forwarded writeback retires one reservation, so the source stays busy
    // only if more than one write was outstanding.
    assign rbusy[p] = (w_addr != '0) &
        (w_hit ? (r_cnt[w_addr] > CNT_WIDTH'(1)) : (r_cnt[w_addr] != '0));
  end

endmodule
